// File: rtl/conv_window_accum_if.sv
// Handshake and data bundle between conv_window_accum, the 3x3 product/sum
// stage it sequences, and the downstream pixel consumer.
// Optional bias input is present only when CONV_WINDOW_BIAS_EN is defined.
// slave  : the accumulator block itself.
// master : the surrounding environment (upstream data source, product/sum
//          stage and downstream consumer).
interface conv_window_accum_if #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PSUM_W-1:0] psum;
    logic [1:0]        select;
    logic [ACC_W-1:0]  acc_out;
    logic [OUT_W-1:0]  pix_out;
    logic              out_valid;
    logic              out_ready;
`ifdef CONV_WINDOW_BIAS_EN
    logic [ACC_W-1:0]  bias;
`endif

    modport slave (
`ifdef CONV_WINDOW_BIAS_EN
        input  bias,
`endif
        input  in_valid, psum, out_ready,
        output in_ready, select, acc_out, pix_out, out_valid
    );

    modport master (
`ifdef CONV_WINDOW_BIAS_EN
        output bias,
`endif
        output in_valid, psum, out_ready,
        input  in_ready, select, acc_out, pix_out, out_valid
    );
endinterface

// File: rtl/conv_window_accum.sv
// conv_window_accum: walks the product/sum stage through columns 0,1,2,
// accumulates the three partial sums into a full 3x3 window sum, requantises
// it (shift + saturate) and offers it on a valid/ready output.
// Optional feature: define CONV_WINDOW_BIAS_EN to add a per-window bias that
// is sampled when the window is accepted and pre-loads the accumulator.
module conv_window_accum #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_accum_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'((1 << OUT_W) - 1);

    state_t            state_reg;
    logic [1:0]        col_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_out_reg;
    logic [OUT_W-1:0]  pix_reg;
    logic              out_valid_reg;

    logic              in_ready;
    logic              accept;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]  pix_next;

`ifdef CONV_WINDOW_BIAS_EN
    logic [ACC_W-1:0]  bias_reg;
`endif

    // Upstream may hand over a new window in IDLE, or in DONE in the same
    // cycle the current result leaves (back-to-back, no bubble).
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Column 0 restarts the sum (from zero or the bias); later columns add on.
    // One extra carry bit lets the sum clamp instead of wrapping; without a
    // bias the carry can never be set, since three full partial sums fit.
    always_comb begin
`ifdef CONV_WINDOW_BIAS_EN
        acc_base = (col_reg == 2'd0) ? bias_reg : acc_reg;
`else
        acc_base = (col_reg == 2'd0) ? '0 : acc_reg;
`endif
        sum_wide = {1'b0, acc_base} + {{(ACC_W + 1 - PSUM_W){1'b0}}, bus.psum};
        acc_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        shifted  = acc_next >> SHIFT;
        pix_next = (shifted > PIX_MAX) ? '1 : shifted[OUT_W-1:0];
    end

    // Window sequencer: column counter doubles as the registered select, so
    // select is 0 everywhere outside MAC and never reaches 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            col_reg       <= 2'd0;
            acc_reg       <= '0;
            acc_out_reg   <= '0;
            pix_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= MAC;
                        col_reg   <= 2'd0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    if (col_reg == 2'd2) begin
                        // Result registered on entry to DONE, held until taken.
                        col_reg       <= 2'd0;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        acc_out_reg   <= acc_next;
                        pix_reg       <= pix_next;
                    end else begin
                        col_reg <= col_reg + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        col_reg       <= 2'd0;
                        state_reg     <= bus.in_valid ? MAC : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    col_reg   <= 2'd0;
                end
            endcase
        end
    end

`ifdef CONV_WINDOW_BIAS_EN
    // Bias belongs to the window being accepted; capture it with the handover.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_reg <= '0;
        end else if (accept) begin
            bias_reg <= bus.bias;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.select    = col_reg;
    assign bus.acc_out   = acc_out_reg;
    assign bus.pix_out   = pix_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_conv_window_accum.sv
// Self-checking bench for conv_window_accum. The product/sum stage is
// modelled as a lookup of the current window's three column sums by select.
// Expected results come from plain arithmetic: sum of columns (plus bias when
// CONV_WINDOW_BIAS_EN is defined, clamped), then shift and clamp to a pixel.
module tb_conv_window_accum;
    localparam int PSUM_W = 16;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 8;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam longint PIX_MAX = (longint'(1) << OUT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_accum_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    conv_window_accum #(
        .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Product/sum stage model: combinational response to select.
    logic [PSUM_W-1:0] col_psum [4];
    always_comb bus.psum = col_psum[bus.select];

    int errors = 0;
    int checks = 0;
    longint bias_val = 0;

    // Observations collected by drive_window.
    logic [1:0]       obs_sel [3];
    logic             obs_mac_valid;
    logic             obs_mac_ready;
    logic             obs_valid;
    logic [ACC_W-1:0] obs_acc;
    logic [OUT_W-1:0] obs_pix;

    function automatic longint model_acc(longint p0, longint p1, longint p2, longint b);
        longint s;
        s = b + p0 + p1 + p2;
        if (s > ACC_MAX) s = ACC_MAX;
        return s;
    endfunction

    function automatic longint model_pix(longint a);
        longint q;
        q = a >> SHIFT;
        return (q > PIX_MAX) ? PIX_MAX : q;
    endfunction

    // Starts from a negedge with the DUT idle; offers one window (in_valid
    // kept high through MAC, which must be ignored) and samples cycles k..k+3.
    task automatic drive_window(input logic [PSUM_W-1:0] p0, input logic [PSUM_W-1:0] p1,
                                input logic [PSUM_W-1:0] p2);
        col_psum[0] = p0;
        col_psum[1] = p1;
        col_psum[2] = p2;
`ifdef CONV_WINDOW_BIAS_EN
        bus.bias = ACC_W'(bias_val);
`endif
        bus.in_valid  = 1'b1;
        obs_mac_valid = 1'b0;
        obs_mac_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs_sel[c]    = bus.select;
            obs_mac_valid = obs_mac_valid | bus.out_valid;
            obs_mac_ready = obs_mac_ready | bus.in_ready;
            if (c == 2) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        obs_valid = bus.out_valid;
        obs_acc   = bus.acc_out;
        obs_pix   = bus.pix_out;
    endtask

    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.select !== 2'd0 || bus.in_ready !== 1'b1 ||
            bus.acc_out !== '0 || bus.pix_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b sel=%0d rdy=%b acc=%0d pix=%0d expected 0 0 1 0 0",
                     bus.out_valid, bus.select, bus.in_ready, bus.acc_out, bus.pix_out);
        end
        // Complete result held in DONE, then discarded by reset.
        drive_window(16'd500, 16'd600, 16'd700);
        checks++;
        if (obs_valid !== 1'b1 || obs_acc !== ACC_W'(1800)) begin
            errors++;
            $display("FAIL reset_pre_window: got valid=%b acc=%0d expected 1 1800", obs_valid, obs_acc);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.acc_out !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_done: got valid=%b acc=%0d rdy=%b expected 0 0 1",
                     bus.out_valid, bus.acc_out, bus.in_ready);
        end
        // Reset mid-MAC, right after select=1 is seen.
        col_psum[0] = 16'd40; col_psum[1] = 16'd50; col_psum[2] = 16'd60;
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.select !== 2'd1) begin
            errors++;
            $display("FAIL reset_mid_sel: got %0d expected 1", bus.select);
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.select !== 2'd0 || bus.in_ready !== 1'b1 ||
            bus.acc_out !== '0 || bus.pix_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_mac: got valid=%b sel=%0d rdy=%b acc=%0d pix=%0d expected 0 0 1 0 0",
                     bus.out_valid, bus.select, bus.in_ready, bus.acc_out, bus.pix_out);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_stale: cycle %0d got out_valid=%b expected 0", i, bus.out_valid);
            end
        end
        bus.out_ready = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_basic;
        drive_window(16'd3, 16'd3, 16'd3);
        checks++;
        if (obs_sel[0] !== 2'd0 || obs_sel[1] !== 2'd1 || obs_sel[2] !== 2'd2) begin
            errors++;
            $display("FAIL basic_select: got %0d,%0d,%0d expected 0,1,2", obs_sel[0], obs_sel[1], obs_sel[2]);
        end
        checks++;
        if (obs_mac_valid !== 1'b0 || obs_mac_ready !== 1'b0 || obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got mac_valid=%b mac_ready=%b valid_k3=%b expected 0 0 1",
                     obs_mac_valid, obs_mac_ready, obs_valid);
        end
        checks++;
        if (obs_acc !== ACC_W'(9) || obs_pix !== OUT_W'(0)) begin
            errors++;
            $display("FAIL basic_result: got acc=%0d pix=%0d expected 9 0", obs_acc, obs_pix);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got valid=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
        $display("basic: acc=%0d pix=%0d", obs_acc, obs_pix);
    endtask

    task automatic test_saturation;
        drive_window(16'hFFFF, 16'hFFFF, 16'hFFFF);
        checks++;
        if (obs_valid !== 1'b1 || obs_acc !== ACC_W'(196605) || obs_pix !== OUT_W'(255)) begin
            errors++;
            $display("FAIL sat_full: got valid=%b acc=%0d pix=%0d expected 1 196605 255",
                     obs_valid, obs_acc, obs_pix);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_window(16'h0100, 16'h0200, 16'h0300);
        checks++;
        if (obs_valid !== 1'b1 || obs_acc !== ACC_W'(16'h0600) || obs_pix !== OUT_W'(6)) begin
            errors++;
            $display("FAIL sat_shift: got valid=%b acc=%0d pix=%0d expected 1 1536 6",
                     obs_valid, obs_acc, obs_pix);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        $display("saturation: done");
    endtask

    task automatic test_backpressure;
        logic [PSUM_W-1:0] p [3];
        longint ea;
        for (int c = 0; c < 3; c++) p[c] = PSUM_W'($urandom_range(0, 65535));
        ea = model_acc(p[0], p[1], p[2], bias_val);
        drive_window(p[0], p[1], p[2]);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.acc_out !== ACC_W'(ea) ||
                bus.pix_out !== OUT_W'(model_pix(ea)) || bus.in_ready !== 1'b0 || bus.select !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got valid=%b acc=%0d pix=%0d rdy=%b sel=%0d expected 1 %0d %0d 0 0",
                         i, bus.out_valid, bus.acc_out, bus.pix_out, bus.in_ready, bus.select,
                         ea, model_pix(ea));
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_follow: got in_ready=%b expected 1", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.select !== 2'd0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b rdy=%b sel=%0d expected 0 1 0",
                     bus.out_valid, bus.in_ready, bus.select);
        end
        bus.out_ready = 1'b0;
        $display("backpressure: acc=%0d", ea);
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        int seen = 0;
        int vcyc [2];
        logic [ACC_W-1:0] vacc [2];
        col_psum[0] = 16'd1; col_psum[1] = 16'd2; col_psum[2] = 16'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
                vcyc[seen] = cyc;
                vacc[seen] = bus.acc_out;
                if (seen == 0) begin
                    checks++;
                    if (bus.in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_ready: got %b expected 1", bus.in_ready);
                    end
                    col_psum[0] = 16'd10; col_psum[1] = 16'd20; col_psum[2] = 16'd30;
                end else begin
                    bus.in_valid = 1'b0;
                end
                seen++;
            end
        end
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results expected 2", seen);
        end else begin
            checks++;
            if (vcyc[0] != 4 || vcyc[1] != 8) begin
                errors++;
                $display("FAIL b2b_spacing: got cycles %0d,%0d expected 4,8", vcyc[0], vcyc[1]);
            end
            checks++;
            if (vacc[0] !== ACC_W'(6) || vacc[1] !== ACC_W'(60)) begin
                errors++;
                $display("FAIL b2b_acc: got %0d,%0d expected 6,60", vacc[0], vacc[1]);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
        $display("back_to_back: done");
    endtask

    task automatic test_random;
        logic [PSUM_W-1:0] p [3];
        longint ea, ep;
        int d;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < 3; c++) p[c] = PSUM_W'($urandom_range(0, 65535));
`ifdef CONV_WINDOW_BIAS_EN
            bias_val = longint'($urandom_range(0, 32'hFFFFF));
`endif
            ea = model_acc(p[0], p[1], p[2], bias_val);
            ep = model_pix(ea);
            d  = $urandom_range(0, 3);
            drive_window(p[0], p[1], p[2]);
            checks++;
            if (obs_sel[0] !== 2'd0 || obs_sel[1] !== 2'd1 || obs_sel[2] !== 2'd2 ||
                obs_valid !== 1'b1 || obs_acc !== ACC_W'(ea) || obs_pix !== OUT_W'(ep)) begin
                errors++;
                $display("FAIL random_%0d: got sel=%0d%0d%0d valid=%b acc=%0d pix=%0d expected 012 1 %0d %0d",
                         n, obs_sel[0], obs_sel[1], obs_sel[2], obs_valid, obs_acc, obs_pix, ea, ep);
            end
            repeat (d) @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_release_%0d: got valid=%b expected 0", n, bus.out_valid);
            end
            bus.out_ready = 1'b0;
            $display("random %0d: psum=%0d,%0d,%0d bias=%0d acc=%0d pix=%0d", n, p[0], p[1], p[2],
                     bias_val, obs_acc, obs_pix);
        end
        bias_val = 0;
    endtask

`ifdef CONV_WINDOW_BIAS_EN
    task automatic test_bias;
        bias_val = 100;
        drive_window(16'd1, 16'd1, 16'd1);
        checks++;
        if (obs_valid !== 1'b1 || obs_acc !== ACC_W'(103) || obs_pix !== OUT_W'(0)) begin
            errors++;
            $display("FAIL bias_add: got valid=%b acc=%0d pix=%0d expected 1 103 0", obs_valid, obs_acc, obs_pix);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bias_val = 64'hFFFFF;
        drive_window(16'd5, 16'd5, 16'd5);
        checks++;
        if (obs_valid !== 1'b1 || obs_acc !== ACC_W'(20'hFFFFF) || obs_pix !== OUT_W'(255)) begin
            errors++;
            $display("FAIL bias_sat: got valid=%b acc=%0d pix=%0d expected 1 1048575 255",
                     obs_valid, obs_acc, obs_pix);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bias_val = 0;
        $display("bias: done");
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        col_psum[0] = '0;
        col_psum[1] = '0;
        col_psum[2] = '0;
        col_psum[3] = 16'hBEEF;
`ifdef CONV_WINDOW_BIAS_EN
        bus.bias = '0;
`endif
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef CONV_WINDOW_BIAS_EN
        test_bias();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_window_accum.md
Name: conv_window_accum

Overview:
- Sequencer and accumulator directly downstream of the 3x3 time-multiplexed product/sum stage.
- Drives that stage's 2-bit column select through 0,1,2 and adds the three 16-bit partial sums into one full 3x3 window result.
- Requantises the result to an output pixel by shift and saturation, then presents it on a valid/ready output handshake.
- Holds upstream, via in_ready, until the window is complete, so image/kernel data stays stable while columns are selected.

Parameters:
- PSUM_W, 16, width of the partial sum from the product/sum stage.
- ACC_W, 20, accumulator width; must be >= PSUM_W+2.
- OUT_W, 8, width of the requantised output pixel.
- SHIFT, 8, right-shift applied to the accumulator before saturation; range 0..ACC_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream window data (image + kernel) present and stable.
- in_ready  out  1  block can accept a new window.
- psum  in  PSUM_W  partial sum returned by the product/sum stage for the current select.
- select  out  2  column select driven to the product/sum stage.
- acc_out  out  ACC_W  full unshifted window sum.
- pix_out  out  OUT_W  requantised, saturated pixel.
- out_valid  out  1  acc_out/pix_out valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- States: IDLE, MAC, DONE. Only the clock edge is sequential; the product/sum stage is combinational, so psum is sampled in the same cycle select is driven.
- Reset (rst=1 at an edge):
  - state=IDLE, select=0, acc=0, out_valid=0, in_ready=1 (combinational from state), acc_out=0, pix_out=0.
  - Reset mid-window or while DONE is held discards the partial/complete result; no out_valid is produced for it.
- IDLE:
  - in_ready=1, select=0.
  - On in_valid&&in_ready go to MAC with column counter=0.
- MAC, one cycle per column:
  - select=counter.
  - counter=0: acc<=psum, zero-extended.
  - counter=1,2: acc<=acc+psum.
  - counter increments each cycle. After the counter=2 cycle, go to DONE.
  - in_ready=0 throughout MAC; in_valid is ignored.
- DONE:
  - out_valid=1. acc_out=acc; pix_out=min(acc>>SHIFT, 2^OUT_W-1). Both are registered on entry to DONE and held stable until the handshake.
  - out_valid&&out_ready with in_valid=0: go to IDLE, out_valid=0 next cycle.
  - in_ready = out_ready in DONE. If out_ready&&in_valid in the same cycle, go straight to MAC with counter=0 (back-to-back, no bubble).
  - out_ready=0: hold all outputs; stay in DONE indefinitely.
- Latency:
  - Window accepted at edge k.
  - select=0,1,2 during cycles k..k+2, i.e. the three cycles after the accepting edge.
  - out_valid first high in cycle k+3.
  - Throughput: one window per 4 cycles, including the DONE cycle.
- Arithmetic:
  - Unsigned throughout.
  - 3*(2^PSUM_W-1) fits ACC_W, so the accumulator never wraps.
  - Saturation compares the full shifted value against 2^OUT_W-1.
- select outside MAC is 0; the value 3 is never driven.

Optional Feature:
- Macro CONV_WINDOW_BIAS_EN.
- When defined:
  - Extra input bias, ACC_W bits, is sampled at the accepting edge.
  - The counter=0 step becomes acc<=bias+psum.
  - Bias is unsigned and the sum saturates at 2^ACC_W-1 instead of wrapping.
- When undefined: no bias port; behaviour exactly as above.

Test Plan:
- Reset: hold rst 2 cycles mid-MAC (after select=1) -> out_valid=0, select=0, in_ready=1, acc_out=0 the cycle after; no stale result ever appears.
- Basic window: psum=3 for all three columns (all-ones data) -> select sequence 0,1,2; out_valid in cycle k+3; acc_out=9, pix_out=0 (SHIFT=8).
- Saturation: psum=0xFFFF each column -> acc_out=0x2FFFD (196605); pix_out=255. Same bench with psum=0x0100, 0x0200, 0x0300 -> acc_out=0x600, pix_out=6.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, acc_out, pix_out stable; in_ready=0. out_ready=1 -> one transfer; IDLE next cycle.
- Back-to-back: in_valid held high, out_ready=1 -> windows with psums {1,2,3} then {10,20,30} give acc_out 6 then 60, out_valid pulses 4 cycles apart, no idle cycle.
- With CONV_WINDOW_BIAS_EN: bias=100, psums {1,1,1} -> acc_out=103. bias=0xFFFFF, psum=5 -> acc_out=0xFFFFF, pix_out=255.
